icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter SETS, default 8: number of direct-mapped lines; power of two, 2..64; INDEX_W = log2(SETS), TAG_W = 28 - INDEX_W.
REQ-002 Block size is fixed at 16 bytes (4 words), addressed by ADDRESS[3:2], not parameterised.
REQ-003 CLK  input  1  single clock; all state updates on posedge.
REQ-004 RESET  input  1  reset; synchronous, active-high.
REQ-005 ADDRESS  input  32  byte fetch address (PC) from the fetch stage; held stable by the pipeline while BUSY_WAIT=1.
REQ-006 INSTRUCTION  output  32  fetched word; drives the IF/ID pipeline register.
REQ-007 BUSY_WAIT  output  1  stall to PC and IF/ID register; 1 = INSTRUCTION not valid this cycle.
REQ-008 MEM_READ  output  1  block read request to instruction memory.
REQ-009 MEM_ADDRESS  output  28  block address to memory, equal to ADDRESS[31:4].
REQ-010 MEM_READDATA  input  128  returned block; word n at bits [32n+31:32n].
REQ-011 MEM_BUSYWAIT  input  1  memory busy; the read completes on the first posedge with MEM_READ=1 and MEM_BUSYWAIT=0.
REQ-012 HIT_COUNT, MISS_COUNT  output  32 each  statistics counters (see Configuration).

Function
REQ-013 Address split: tag = ADDRESS[31:4+INDEX_W], index = ADDRESS[3+INDEX_W:4], word offset = ADDRESS[3:2]; ADDRESS[1:0] ignored.
REQ-014 Per line storage: valid bit, tag, 128-bit data.
REQ-015 FSM states: IDLE, MEM_READ; encoding is implementer's choice.
REQ-016 IDLE with hit (valid[index] and tag match): BUSY_WAIT=0 combinationally in the same cycle; INSTRUCTION = selected word, combinational from array and offset; zero-cycle hit latency.
REQ-017 IDLE with miss: BUSY_WAIT=1 in the same cycle; next posedge -> MEM_READ.
REQ-018 MEM_READ: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4], BUSY_WAIT=1.
REQ-019 MEM_READ, posedge with MEM_BUSYWAIT=0: write MEM_READDATA, tag, valid=1 into the line; -> IDLE.
REQ-020 MEM_READ, posedge with MEM_BUSYWAIT=1: remain in MEM_READ; MEM_READ stays 1 and MEM_ADDRESS stays unchanged.
REQ-021 After a fill, the following IDLE cycle hits; BUSY_WAIT drops one cycle after the completing edge. Miss penalty = memory wait cycles + 2.
REQ-022 A fill replaces the line unconditionally; no write-back (read-only cache).
REQ-023 MEM_READ=0 in IDLE; MEM_ADDRESS = ADDRESS[31:4] in every state.
REQ-024 INSTRUCTION is don't-care while BUSY_WAIT=1 and is not checked by the bench there.
REQ-025 Address changes while BUSY_WAIT=1 are illegal; behaviour is undefined and need not be detected.

Reset
REQ-026 RESET=1 at a posedge clears all valid bits, forces state IDLE, and clears HIT_COUNT and MISS_COUNT; tag and data arrays are not cleared.
REQ-027 While RESET=1: BUSY_WAIT=0, INSTRUCTION=32'h0, MEM_READ=0 combinationally, so the IF/ID register loads a zero word.
REQ-028 Reset during MEM_READ aborts the fill: MEM_READ drops in the same cycle, no line is written, and a late memory completion is ignored.
REQ-029 The first fetch after reset release always misses.

Configuration
REQ-030 Macro ICACHE_STATS_EN.
- Defined: HIT_COUNT increments on each non-reset IDLE hit cycle; MISS_COUNT increments on each IDLE->MEM_READ transition; both wrap modulo 2^32.
- Undefined: both outputs are tied to 32'h0 and no counter flops are synthesised.
- Hit/miss behaviour is identical in both builds.

Verification
REQ-031 Reset, then ADDRESS=0x0000_0000, memory latency 3 -> BUSY_WAIT=1 for 5 cycles, MEM_READ=1 with MEM_ADDRESS=0x0000000, then INSTRUCTION = word0 of the block with BUSY_WAIT=0.
REQ-032 After REQ-031, ADDRESS 0x4, 0x8, 0xC in consecutive cycles -> BUSY_WAIT=0 every cycle, INSTRUCTION = words 1..3, MEM_READ never asserted.
REQ-033 SETS=8, fill 0x0000_0000, then fetch 0x0000_0080 (same index, different tag) -> miss, line replaced; a refetch of 0x0000_0000 misses again.
REQ-034 RESET=1 for 1 cycle at the 2nd MEM_READ cycle, memory completing 1 cycle later -> MEM_READ=0 and BUSY_WAIT=0 during reset; the next fetch of the same address misses.
REQ-035 MEM_BUSYWAIT held 1 for 20 cycles -> MEM_READ and BUSY_WAIT stay 1 throughout; MEM_ADDRESS is constant.
REQ-036 With ICACHE_STATS_EN: the REQ-031 to REQ-033 sequence -> MISS_COUNT=3, HIT_COUNT=4. Without the macro -> both read 0.

Source files
------------

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, 16-byte lines, zero-cycle hits.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache #(
    parameter int SETS = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSY_WAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic {
        S_IDLE,
        S_MEM_READ
    } state_t;

    state_t             state_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [127:0]       data_q [SETS];

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_offset;
    logic               hit;
    logic               fill_en;
    logic [127:0]       line;
    logic [31:0]        line_word;
    logic               addr_unused;

    assign addr_tag    = ADDRESS[31:4+INDEX_W];
    assign addr_index  = ADDRESS[3+INDEX_W:4];
    assign addr_offset = ADDRESS[3:2];
    assign addr_unused = ^ADDRESS[1:0];

    assign hit     = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
    assign fill_en = !RESET && (state_q == S_MEM_READ) && !MEM_BUSYWAIT;

    assign line = data_q[addr_index];
    always_comb begin
        line_word = line[31:0];
        case (addr_offset)
            2'd0: line_word = line[31:0];
            2'd1: line_word = line[63:32];
            2'd2: line_word = line[95:64];
            2'd3: line_word = line[127:96];
            default: line_word = line[31:0];
        endcase
    end

    // Reset overrides everything so the IF/ID register captures a zero word.
    assign INSTRUCTION = RESET ? 32'h0 : line_word;
    assign BUSY_WAIT   = RESET ? 1'b0 : ((state_q == S_IDLE) ? !hit : 1'b1);
    assign MEM_READ    = !RESET && (state_q == S_MEM_READ);
    assign MEM_ADDRESS = ADDRESS[31:4];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            valid_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!hit) begin
                        state_q <= S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    if (!MEM_BUSYWAIT) begin
                        valid_q[addr_index] <= 1'b1;
                        state_q             <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[addr_index]  <= addr_tag;
            data_q[addr_index] <= MEM_READDATA;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else if (state_q == S_IDLE) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'h1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'h1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`else
    assign HIT_COUNT  = 32'h0;
    assign MISS_COUNT = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache with a latency-modelled instruction memory.
module tb_icache;
    logic         CLK;
    logic         RESET;
    logic [31:0]  ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSY_WAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 3;
    int wcnt;
    bit force_en;
    bit force_val;
    logic [31:0] sb[$];

    icache #(.SETS(8)) dut (
        .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .INSTRUCTION(INSTRUCTION),
        .BUSY_WAIT(BUSY_WAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {a[31:4], a[3:2], 2'b01} ^ 32'hC3A5_0000;
    endfunction

    // Memory: busy for lat cycles of MEM_READ, then completes; force_en overrides busy.
    always_ff @(posedge CLK) begin
        if (force_en || !MEM_READ) wcnt <= 0;
        else if (wcnt < lat) wcnt <= wcnt + 1;
    end
    assign MEM_BUSYWAIT = force_en ? force_val : (MEM_READ && (wcnt < lat));
    always_comb begin
        MEM_READDATA = '0;
        for (int n = 0; n < 4; n++) begin
            logic [1:0] w;
            w = n[1:0];
            MEM_READDATA[32*n +: 32] = exp_word({MEM_ADDRESS, w, 2'b00});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check("miss_count", MISS_COUNT, 32'd3);
        check("hit_count", HIT_COUNT, 32'd4);
`else
        check("miss_count", MISS_COUNT, 32'd0);
        check("hit_count", HIT_COUNT, 32'd0);
`endif
    endtask

    // Drives one fetch; early=1 returns right after the fill-completing edge.
    task automatic fetch(input logic [31:0] a, input int exp_busy, input int exp_mr,
                         input bit early, input bit chk);
        int busy_n = 0;
        int mr_n = 0;
        int addr_bad = 0;
        int cyc = 0;
        bit done = 0;
        bit last;
        ADDRESS = a;
        if (!early) sb.push_back(exp_word(a));
        while (!done && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (chk && busy_n == 1) check_stats();
            if (MEM_READ) begin
                mr_n++;
                if (MEM_ADDRESS !== a[31:4]) addr_bad++;
            end
            if (BUSY_WAIT) begin
                busy_n++;
                last = MEM_READ && !MEM_BUSYWAIT;
                @(posedge CLK); #1;
                if (early && last) done = 1;
            end else begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    check($sformatf("instr@%h", a), INSTRUCTION, sb.pop_front());
                end
                done = 1;
                @(posedge CLK); #1;
            end
        end
        if (!done) check($sformatf("timeout@%h", a), 32'd0, 32'd1);
        check($sformatf("busy_cycles@%h", a), busy_n, exp_busy);
        check($sformatf("mem_read_cycles@%h", a), mr_n, exp_mr);
        check($sformatf("mem_addr@%h", a), addr_bad, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          busy;
        int          mr;
        bit          early;
        bit          chk;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int bad;
        tbl[0] = '{32'h0000_0000, 5, 4, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0004, 0, 0, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0008, 0, 0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_000C, 0, 0, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0080, 5, 4, 1'b1, 1'b0};
        tbl[5] = '{32'h0000_0000, 5, 4, 1'b0, 1'b1};
        tbl[6] = '{32'h0000_003C, 5, 4, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0038, 0, 0, 1'b0, 1'b0};
        tbl[8] = '{32'h0000_0004, 0, 0, 1'b0, 1'b0};

        RESET = 1'b1; ADDRESS = 32'h0; force_en = 1'b0; force_val = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_busy", BUSY_WAIT, 1'b0);
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_instr", INSTRUCTION, 32'h0);
        check("rst_hit_count", HIT_COUNT, 32'h0);
        check("rst_miss_count", MISS_COUNT, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        for (int i = 0; i < 9; i++) begin
            fetch(tbl[i].addr, tbl[i].busy, tbl[i].mr, tbl[i].early, tbl[i].chk);
        end

        // Reset in the second MEM_READ cycle; memory completes the cycle after.
        ADDRESS = 32'h0000_0110; force_en = 1'b1; force_val = 1'b1;
        @(negedge CLK);
        check("abort_first_miss", BUSY_WAIT, 1'b1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("abort_mem_read1", MEM_READ, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_rst_mem_read", MEM_READ, 1'b0);
        check("abort_rst_busy", BUSY_WAIT, 1'b0);
        check("abort_rst_instr", INSTRUCTION, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0; force_val = 1'b0;
        @(negedge CLK);
        check("abort_late_ignored", BUSY_WAIT, 1'b1);
        check("abort_idle_mem_read", MEM_READ, 1'b0);
        @(posedge CLK); #1;
        force_en = 1'b0;
        fetch(32'h0000_0110, 4, 4, 1'b0, 1'b0);
        fetch(32'h0000_0114, 0, 0, 1'b0, 1'b0);
        fetch(32'h0000_0000, 5, 4, 1'b0, 1'b0);

        // Memory held busy for 20 cycles.
        ADDRESS = 32'h0000_0224; force_en = 1'b1; force_val = 1'b1;
        @(negedge CLK);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            if (!MEM_READ || !BUSY_WAIT || MEM_ADDRESS !== 28'h000_0022) bad++;
        end
        check("long_wait_stable", bad, 0);
        @(posedge CLK); #1;
        force_en = 1'b0;
        fetch(32'h0000_0224, 4, 4, 1'b0, 1'b0);
        fetch(32'h0000_0228, 0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
